// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared types and constants for the integer pipeline:
//                register index type, forwarding-source select encoding and
//                the hard-wired zero register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/operand_forward.sv
`default_nettype none
// ============================================================================
//  Module      : operand_forward
//  Description : Combinational operand resolver. Picks the youngest in-flight
//                producer of register idx (EX, then MEM, then WB) and falls
//                back to the register-file read value. Index 0 always reads 0.
//  Ports       : idx             - register index being read
//                rf_val          - register-file read value for idx
//                ex_en/dst/val   - EX producer (enable already excludes loads)
//                mem_en/dst/val  - MEM producer
//                wb_dst/val      - WB producer (dst 0 means no write)
//                val             - resolved operand
//                sel             - which source supplied val
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_forward
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  reg_idx_t          idx,
    input  logic [DATA_W-1:0] rf_val,
    input  logic              ex_en,
    input  reg_idx_t          ex_dst,
    input  logic [DATA_W-1:0] ex_val,
    input  logic              mem_en,
    input  reg_idx_t          mem_dst,
    input  logic [DATA_W-1:0] mem_val,
    input  reg_idx_t          wb_dst,
    input  logic [DATA_W-1:0] wb_val,
    output logic [DATA_W-1:0] val,
    output fwd_sel_e          sel
);

    always_comb begin
        sel = FWD_RF;
        if (idx != REG_ZERO) begin
            if (ex_en && (ex_dst == idx)) begin
                sel = FWD_EX;
            end else if (mem_en && (mem_dst == idx)) begin
                sel = FWD_MEM;
            end else if (wb_dst == idx) begin
                // Needed because the regfile write lands at the same edge
                // that this read is being captured on.
                sel = FWD_WB;
            end
        end
    end

    always_comb begin
        val = rf_val;
        if (idx == REG_ZERO) begin
            val = '0;
        end else begin
            case (sel)
                FWD_EX:  val = ex_val;
                FWD_MEM: val = mem_val;
                FWD_WB:  val = wb_val;
                default: val = rf_val;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID->EX pipeline register. Resolves both operands through
//                EX/MEM/WB forwarding at capture, detects load-use hazards
//                (one bubble), honours flush and downstream hold, and counts
//                stall cycles with saturation.
//  Ports       : clk, reset (sync, active-low)
//                id_*        - decoded instruction and regfile read values
//                ex_result   - ALU result of the instruction now in EX
//                mem_*, wb_* - later-stage producers for forwarding
//                flush       - kill the instruction entering EX
//                ex_busy     - EX cannot accept this cycle
//                ex_*_o, ex_a, ex_b - stage register contents
//                id_stall    - ID/IF must hold (combinational)
//                stall_cnt   - saturating count of stalled cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  reg_idx_t          id_rs,
    input  reg_idx_t          id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_v1,
    input  logic [DATA_W-1:0] id_v2,
    input  reg_idx_t          id_dst,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_is_load,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_valid,
    input  reg_idx_t          mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    input  reg_idx_t          wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_busy,
    output logic              ex_valid_o,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm_o,
    output reg_idx_t          ex_dst_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              ex_is_load_o,
    output logic              id_stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A load in EX has no data yet, so it must not be an EX forward source;
    // that case is covered by the load-use bubble instead.
    logic w_ex_fwd_en;
    assign w_ex_fwd_en = ex_valid_o & ~ex_is_load_o;

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    fwd_sel_e          w_sel_a;
    fwd_sel_e          w_sel_b;

    operand_forward #(.DATA_W(DATA_W)) u_fwd_rs (
        .idx     (id_rs),
        .rf_val  (id_v1),
        .ex_en   (w_ex_fwd_en),
        .ex_dst  (ex_dst_o),
        .ex_val  (ex_result),
        .mem_en  (mem_valid),
        .mem_dst (mem_dst),
        .mem_val (mem_data),
        .wb_dst  (wb_dst),
        .wb_val  (wb_data),
        .val     (w_a),
        .sel     (w_sel_a)
    );

    operand_forward #(.DATA_W(DATA_W)) u_fwd_rt (
        .idx     (id_rt),
        .rf_val  (id_v2),
        .ex_en   (w_ex_fwd_en),
        .ex_dst  (ex_dst_o),
        .ex_val  (ex_result),
        .mem_en  (mem_valid),
        .mem_dst (mem_dst),
        .mem_val (mem_data),
        .wb_dst  (wb_dst),
        .wb_val  (wb_data),
        .val     (w_b),
        .sel     (w_sel_b)
    );

    // Source selects are kept for debug visibility only.
    logic [3:0] w_unused_sel;
    assign w_unused_sel = {w_sel_a, w_sel_b};

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_hazard;
    assign w_rs_hit = id_uses_rs & (id_rs == ex_dst_o);
    assign w_rt_hit = id_uses_rt & (id_rt == ex_dst_o);
    assign w_hazard = id_valid & ex_valid_o & ex_is_load_o &
                      (ex_dst_o != REG_ZERO) & (w_rs_hit | w_rt_hit);

    assign id_stall = ~flush & (ex_busy | w_hazard);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid_o   <= 1'b0;
            ex_a         <= '0;
            ex_b         <= '0;
            ex_imm_o     <= '0;
            ex_dst_o     <= REG_ZERO;
            ex_ctrl_o    <= '0;
            ex_is_load_o <= 1'b0;
        end else if (flush) begin
            ex_valid_o <= 1'b0;
        end else if (ex_busy) begin
            // EX is holding its instruction: every field keeps its value.
        end else if (w_hazard) begin
            // Bubble; next cycle the load sits in MEM and forwards from there.
            ex_valid_o <= 1'b0;
        end else begin
            ex_valid_o   <= id_valid;
            ex_a         <= w_a;
            ex_b         <= w_b;
            ex_imm_o     <= id_imm;
            ex_dst_o     <= id_dst;
            ex_ctrl_o    <= id_ctrl;
            ex_is_load_o <= id_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (id_stall && (stall_cnt != C_CNT_MAX)) begin
            stall_cnt <= stall_cnt + C_CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage. A behavioural model of
//                the stage runs alongside two DUT instances (32-bit and 4-bit
//                stall counters) and is compared on every falling edge;
//                directed scenarios pin the model with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_uses_rs, id_uses_rt, id_is_load;
    logic [31:0] id_v1, id_v2, id_imm, ex_result, mem_data, wb_data;
    logic [7:0]  id_ctrl;
    logic        mem_valid;
    logic [4:0]  mem_dst, wb_dst;
    logic        flush, ex_busy;

    logic        ex_valid_o, ex_is_load_o, id_stall;
    logic [31:0] ex_a, ex_b, ex_imm_o;
    logic [4:0]  ex_dst_o;
    logic [7:0]  ex_ctrl_o;
    logic [31:0] stall_cnt;

    logic        s_valid, s_is_load, s_stall;
    logic [31:0] s_a, s_b, s_imm;
    logic [4:0]  s_dst;
    logic [7:0]  s_ctrl;
    logic [3:0]  s_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .CTRL_W(8), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_v1(id_v1), .id_v2(id_v2),
        .id_dst(id_dst), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_is_load(id_is_load),
        .ex_result(ex_result), .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data),
        .wb_dst(wb_dst), .wb_data(wb_data), .flush(flush), .ex_busy(ex_busy),
        .ex_valid_o(ex_valid_o), .ex_a(ex_a), .ex_b(ex_b), .ex_imm_o(ex_imm_o),
        .ex_dst_o(ex_dst_o), .ex_ctrl_o(ex_ctrl_o), .ex_is_load_o(ex_is_load_o),
        .id_stall(id_stall), .stall_cnt(stall_cnt)
    );

    id_ex_stage #(.DATA_W(32), .CTRL_W(8), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_v1(id_v1), .id_v2(id_v2),
        .id_dst(id_dst), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_is_load(id_is_load),
        .ex_result(ex_result), .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data),
        .wb_dst(wb_dst), .wb_data(wb_data), .flush(flush), .ex_busy(ex_busy),
        .ex_valid_o(s_valid), .ex_a(s_a), .ex_b(s_b), .ex_imm_o(s_imm),
        .ex_dst_o(s_dst), .ex_ctrl_o(s_ctrl), .ex_is_load_o(s_is_load),
        .id_stall(s_stall), .stall_cnt(s_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_init  = 1'b0;
    logic        m_known = 1'b0;  // fields have defined values
    logic        m_valid, m_load;
    logic [31:0] m_a, m_b, m_imm;
    logic [4:0]  m_dst;
    logic [7:0]  m_ctrl;
    longint      m_cnt, m_cnt4;

    // Value an instruction in ID must see for register idx.
    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0)                              return 32'd0;
        if (m_valid && !m_load && m_dst == idx)       return ex_result;
        if (mem_valid && mem_dst == idx)              return mem_data;
        if (wb_dst == idx)                            return wb_data;
        return rf;
    endfunction

    function automatic logic load_use();
        return id_valid && m_valid && m_load && m_dst != 5'd0 &&
               ((id_uses_rs && id_rs == m_dst) || (id_uses_rt && id_rt == m_dst));
    endfunction

    function automatic logic exp_stall();
        return !flush && (ex_busy || load_use());
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_init <= 1'b1; m_known <= 1'b1;
            m_valid <= 1'b0; m_load <= 1'b0; m_a <= 0; m_b <= 0; m_imm <= 0;
            m_dst <= 0; m_ctrl <= 0; m_cnt <= 0; m_cnt4 <= 0;
        end else begin
            if (exp_stall()) begin
                m_cnt  <= (m_cnt  == 64'hFFFF_FFFF) ? m_cnt  : m_cnt + 1;
                m_cnt4 <= (m_cnt4 == 15)            ? m_cnt4 : m_cnt4 + 1;
            end
            if (flush || (!ex_busy && load_use())) begin
                m_valid <= 1'b0; m_known <= 1'b0;
            end else if (!ex_busy) begin
                m_valid <= id_valid; m_known <= 1'b1;
                m_a <= operand(id_rs, id_v1); m_b <= operand(id_rt, id_v2);
                m_imm <= id_imm; m_dst <= id_dst; m_ctrl <= id_ctrl; m_load <= id_is_load;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_init) begin
            chk("ex_valid", ex_valid_o, m_valid);
            chk("ex_valid_sat", s_valid, m_valid);
            if (m_known) begin
                chk("ex_a", ex_a, m_a);
                chk("ex_b", ex_b, m_b);
                chk("ex_imm", ex_imm_o, m_imm);
                chk("ex_dst", ex_dst_o, m_dst);
                chk("ex_ctrl", ex_ctrl_o, m_ctrl);
                chk("ex_is_load", ex_is_load_o, m_load);
            end
            chk("id_stall", id_stall, exp_stall());
            chk("stall_cnt", stall_cnt, m_cnt);
            chk("stall_cnt_sat", s_cnt, m_cnt4);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_v1 = 0; id_v2 = 0; id_dst = 0; id_imm = 0; id_ctrl = 0; id_is_load = 0;
        ex_result = 0; mem_valid = 0; mem_dst = 0; mem_data = 0; wb_dst = 0; wb_data = 0;
        flush = 0; ex_busy = 0;
    endtask

    task automatic rand_in();
        id_valid   = ($urandom_range(0, 7) != 0);
        id_rs      = 5'($urandom_range(0, 7));
        id_rt      = 5'($urandom_range(0, 7));
        id_uses_rs = 1'($urandom);
        id_uses_rt = 1'($urandom);
        id_v1      = $urandom; id_v2 = $urandom; id_imm = $urandom;
        id_dst     = 5'($urandom_range(0, 7));
        id_ctrl    = 8'($urandom);
        id_is_load = ($urandom_range(0, 2) == 0);
        ex_result  = $urandom;
        mem_valid  = 1'($urandom);
        mem_dst    = 5'($urandom_range(0, 7));
        mem_data   = $urandom;
        wb_dst     = 5'($urandom_range(0, 7));
        wb_data    = $urandom;
        flush      = ($urandom_range(0, 15) == 0);
        ex_busy    = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        // Reset with random inputs for two cycles.
        reset = 0;
        rand_in();
        tick();
        rand_in();
        ex_busy = 0;
        tick();
        chk("rst_valid", ex_valid_o, 0);
        chk("rst_a", ex_a, 0);
        chk("rst_b", ex_b, 0);
        chk("rst_imm", ex_imm_o, 0);
        chk("rst_dst", ex_dst_o, 0);
        chk("rst_ctrl", ex_ctrl_o, 0);
        chk("rst_load", ex_is_load_o, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_stall", id_stall, 0);

        // EX forward: non-load with dst=5 enters EX, then ID reads rs=5.
        reset = 1;
        clear_in();
        id_valid = 1; id_dst = 5;
        tick();
        id_rs = 5; id_uses_rs = 1; id_v1 = 32'h11; ex_result = 32'hAB; id_dst = 1;
        tick();
        chk("exfwd_a", ex_a, 32'hAB);

        // MEM beats WB beats regfile; index 0 reads 0.
        clear_in();
        id_valid = 1; id_rt = 7; id_uses_rt = 1; id_v2 = 32'h44; id_v1 = 32'h55;
        mem_valid = 1; mem_dst = 7; mem_data = 32'h22; wb_dst = 7; wb_data = 32'h33;
        tick();
        chk("prio_b", ex_b, 32'h22);
        chk("zero_a", ex_a, 0);
        id_rt = 0;
        tick();
        chk("zero_b", ex_b, 0);

        // Load-use: load dst=8 in EX, consumer reads rs=8.
        clear_in();
        id_valid = 1; id_is_load = 1; id_dst = 8;
        tick();
        clear_in();
        id_valid = 1; id_rs = 8; id_uses_rs = 1; id_v1 = 32'h5; id_dst = 2;
        #1;
        chk("lu_stall", id_stall, 1);
        tick();
        chk("lu_bubble", ex_valid_o, 0);
        chk("lu_cnt", stall_cnt, 1);
        mem_valid = 1; mem_dst = 8; mem_data = 32'h99;
        #1;
        chk("lu_stall_clr", id_stall, 0);
        tick();
        chk("lu_valid", ex_valid_o, 1);
        chk("lu_a", ex_a, 32'h99);

        // Hold for 3 cycles, then flush during hold.
        clear_in();
        id_valid = 1; id_rs = 3; id_uses_rs = 1; id_v1 = 32'h1234;
        ex_busy = 1;
        #1;
        chk("busy_stall", id_stall, 1);
        repeat (3) tick();
        chk("busy_a", ex_a, 32'h99);
        chk("busy_valid", ex_valid_o, 1);
        chk("busy_cnt", stall_cnt, 4);
        flush = 1;
        #1;
        chk("flush_stall", id_stall, 0);
        tick();
        chk("flush_valid", ex_valid_o, 0);
        chk("flush_cnt", stall_cnt, 4);

        // Continuous stall for 20 cycles: 4-bit counter saturates.
        flush = 0;
        repeat (20) tick();
        chk("sat_cnt4", s_cnt, 15);
        chk("sat_cnt32", stall_cnt, 24);

        // Randomized traffic, including resets mid-hold / mid-hazard.
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            reset = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
